mem_port_arbiter: RTL and testbench

Sequencing controller and arbiter for the single byte-wide memory port shared by instruction fetch and data load/store in the tinker core. It accepts word requests from two requesters:
- fetch: 4-byte read.
- data: 8-byte read or write.

It grants one requester at a time under round-robin priority and moves the word as a little-endian byte-serial burst, one byte per clock. It returns the assembled word with a one-cycle acknowledge and rejects out-of-range accesses without touching memory.

---
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and byte-serial sequencer sharing one byte-wide memory
// port between a 4-byte fetch requester and an 8-byte load/store requester.
module mem_port_arbiter #(
  parameter int ADDR_W    = 64,
  parameter int MEM_BYTES = 524288
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_ack,
  output logic [63:0]       d_rdata,
  output logic              err,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  // Handshake: a requester holds req high with stable operands until it sees
  // a one-cycle ack, then drops req on that same edge; ack is never retracted.

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_XFER  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  localparam logic [ADDR_W-1:0] MEM_SIZE = ADDR_W'(MEM_BYTES);

  logic [1:0]        state;
  logic [ADDR_W-1:0] base;
  logic              we_q;
  logic [63:0]       wdata_q;
  logic [3:0]        len_q;
  logic [3:0]        cnt;
  logic              gnt_data;
  logic              last_data;
  logic              err_q;
  logic [63:0]       rbuf;

  logic              pick_data;
  logic [3:0]        sel_len;
  logic [ADDR_W-1:0] sel_base;
  logic              sel_ok;
  logic              capture;
  logic [3:0]        rd_idx;

  // Both requesting: the side not granted last wins.
  assign pick_data = d_req & (~if_req | ~last_data);
  assign sel_len   = pick_data ? 4'd8 : 4'd4;
  assign sel_base  = pick_data ? d_addr : if_addr;
  assign sel_ok    = sel_base <= (MEM_SIZE - {{(ADDR_W-4){1'b0}}, sel_len});

  // The synchronous memory returns each byte one cycle late, so byte cnt-1
  // lands while cnt is strobing; DRAIN (cnt == len) picks up the last one.
  assign capture = ~we_q & (((state == S_XFER) & (cnt != 4'd0)) | (state == S_DRAIN));
  assign rd_idx  = cnt - 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      base      <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      len_q     <= '0;
      cnt       <= '0;
      gnt_data  <= 1'b0;
      last_data <= 1'b1;
      err_q     <= 1'b0;
      rbuf      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (if_req | d_req) begin
            gnt_data  <= pick_data;
            last_data <= pick_data;
            base      <= sel_base;
            we_q      <= pick_data & d_we;
            wdata_q   <= pick_data ? d_wdata : 64'd0;
            len_q     <= sel_len;
            cnt       <= 4'd0;
            rbuf      <= '0;
            err_q     <= ~sel_ok;
            state     <= sel_ok ? S_XFER : S_ACK;
          end
        end
        S_XFER: begin
          cnt <= cnt + 4'd1;
          if (cnt == len_q - 4'd1) state <= S_DRAIN;
        end
        S_DRAIN: state <= S_ACK;
        default: state <= S_IDLE;
      endcase
      if (capture) rbuf[{rd_idx[2:0], 3'b000} +: 8] <= mem_rdata;
    end
  end

  assign busy      = state != S_IDLE;
  assign mem_en    = state == S_XFER;
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = mem_en ? (base + {{(ADDR_W-4){1'b0}}, cnt}) : '0;
  assign mem_wdata = mem_en ? wdata_q[{cnt[2:0], 3'b000} +: 8] : 8'd0;
  assign if_ack    = (state == S_ACK) & ~gnt_data;
  assign d_ack     = (state == S_ACK) & gnt_data;
  assign err       = (state == S_ACK) & err_q;
  assign if_rdata  = if_ack ? rbuf[31:0] : 32'd0;
  assign d_rdata   = (d_ack & ~we_q) ? rbuf : 64'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte memory model, two requester drivers and a
// transaction-level reference model predicting grants, timing and data.
module tb_mem_port_arbiter;

  localparam int MEM = 524288;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          delay;
  } job_t;

  logic        clk, reset;
  logic        if_req, if_ack;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_ack;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic        err, busy, mem_en, mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(64), .MEM_BYTES(MEM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .err(err), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous byte memory
  logic [7:0] tb_mem  [0:MEM-1];
  logic [7:0] ref_mem [0:MEM-1];
  initial mem_rdata = 8'd0;
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= tb_mem[mem_addr[18:0]];
      if (mem_we) tb_mem[mem_addr[18:0]] = mem_wdata;
    end
  end

  // Scoreboard state
  int n_cmp = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];
  job_t if_q[$];
  job_t d_q[$];
  job_t if_cur, d_cur;
  bit   grant_q[$];

  bit          m_active, m_ok, m_is_data, m_we, m_last_data;
  int          m_gnt, m_ack, m_free, m_len;
  logic [63:0] m_base, m_wdata;

  int          last_ack_c;
  logic        last_err;
  logic [31:0] last_if_rdata;
  logic [63:0] last_d_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: one word at a time; latency len+2 when in range, 1 when not.
  task automatic model_grant(input int c, input bit f_on, input bit dt_on);
    bit pd;
    job_t j;
    logic [63:0] e;
    pd        = dt_on && (!f_on || !m_last_data);
    j         = pd ? d_cur : if_cur;
    m_len     = pd ? 8 : 4;
    m_is_data = pd;
    m_we      = pd && j.we;
    m_base    = j.addr;
    m_wdata   = pd ? j.wdata : 64'd0;
    m_ok      = j.addr <= 64'(MEM - m_len);
    m_gnt     = c;
    m_ack     = c + (m_ok ? m_len + 2 : 1);
    m_free    = m_ack + 1;
    m_active  = 1;
    m_last_data = pd;
    grant_q.push_back(pd);
    e = 64'd0;
    if (m_ok) begin
      for (int i = 0; i < m_len; i++) begin
        if (m_we) ref_mem[int'(m_base) + i] = m_wdata[8*i +: 8];
        else e[8*i +: 8] = ref_mem[int'(m_base) + i];
      end
    end
    exp_q.push_back(e);
  endtask

  // Drives both requester queues and checks every output each cycle.
  task automatic run_engine(input int max_c);
    int c, if_wait, d_wait, off;
    bit if_on, d_on, if_done, d_done, in_xfer, at_ack, act, fin;
    logic [63:0] e_rd;
    job_t j;
    c = 0; if_on = 0; d_on = 0; if_wait = -1; d_wait = -1;
    m_active = 0; m_free = 0; fin = 0;
    grant_q.delete();
    while (!fin && c < max_c) begin
      @(negedge clk);
      at_ack  = m_active && (c == m_ack);
      act     = m_active && (c > m_gnt);
      in_xfer = act && m_ok && (c <= m_gnt + m_len);
      off     = c - m_gnt - 1;
      e_rd    = 64'd0;
      if (at_ack) e_rd = exp_q.pop_front();
      chk("busy", busy, act);
      chk("mem_en", mem_en, in_xfer);
      if (in_xfer) begin
        chk("mem_addr", mem_addr, m_base + 64'(off));
        chk("mem_we", mem_we, m_we);
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata[8*off +: 8]);
      end else begin
        chk("mem_we_off", mem_we, 0);
        chk("mem_wdata_off", mem_wdata, 0);
      end
      if (!act) chk("mem_addr_idle", mem_addr, 0);
      chk("if_ack", if_ack, at_ack && !m_is_data);
      chk("d_ack", d_ack, at_ack && m_is_data);
      chk("err", err, at_ack && !m_ok);
      chk("if_rdata", if_rdata, (at_ack && !m_is_data) ? e_rd[31:0] : 64'd0);
      chk("d_rdata", d_rdata, (at_ack && m_is_data) ? e_rd : 64'd0);
      if (at_ack) m_active = 0;
      if (if_ack || d_ack) begin
        last_ack_c = c; last_err = err;
        if (if_ack) last_if_rdata = if_rdata;
        if (d_ack) last_d_rdata = d_rdata;
      end
      if_done = if_on && if_ack;
      d_done  = d_on && d_ack;
      if (if_done) begin if_on = 0; if_req = 0; end
      if (d_done) begin d_on = 0; d_req = 0; end
      if (!if_on && !if_done && if_q.size() > 0) begin
        if (if_wait < 0) if_wait = if_q[0].delay;
        if (if_wait == 0) begin
          j = if_q.pop_front(); if_cur = j;
          if_addr = j.addr; if_req = 1; if_on = 1; if_wait = -1;
        end else if_wait--;
      end
      if (!d_on && !d_done && d_q.size() > 0) begin
        if (d_wait < 0) d_wait = d_q[0].delay;
        if (d_wait == 0) begin
          j = d_q.pop_front(); d_cur = j;
          d_we = j.we; d_addr = j.addr; d_wdata = j.wdata;
          d_req = 1; d_on = 1; d_wait = -1;
        end else d_wait--;
      end
      if (!m_active && c >= m_free && (if_on || d_on)) model_grant(c, if_on, d_on);
      fin = !if_on && !d_on && !m_active && if_q.size() == 0 && d_q.size() == 0;
      c++;
    end
    chk("engine_done", fin, 1);
    if_req = 0; d_req = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    @(negedge clk);
    reset = 1;
    m_last_data = 1;
  endtask

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 9))
      0: return 64'(MEM - 12 + $urandom_range(0, 11));
      1: return {$urandom, $urandom};
      default: return 64'(32'h400 + $urandom_range(0, 'hF8));
    endcase
  endfunction

  initial begin
    logic [63:0] w;
    logic [7:0]  b;
    reset = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    m_last_data = 1;
    for (int i = 0; i < MEM; i++) begin tb_mem[i] = 8'd0; ref_mem[i] = 8'd0; end
    for (int i = 'h400; i < 'h500; i++) begin
      b = 8'($urandom); tb_mem[i] = b; ref_mem[i] = b;
    end
    for (int i = 0; i < 4; i++) begin
      b = 8'(8'h11 * (i + 1)); tb_mem['h2000 + i] = b; ref_mem['h2000 + i] = b;
    end
    #1 reset = 0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_mem_en", mem_en, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_if_ack", if_ack, 0);
    chk("reset_d_ack", d_ack, 0);
    chk("reset_err", err, 0);
    chk("reset_if_rdata", if_rdata, 0);
    chk("reset_d_rdata", d_rdata, 0);
    reset = 1;

    // Fetch of a known word
    if_q.push_back('{we: 0, addr: 64'h2000, wdata: 0, delay: 0});
    run_engine(50);
    chk("fetch_word", last_if_rdata, 32'h44332211);
    chk("fetch_ack_cycle", last_ack_c, 6);
    chk("fetch_err", last_err, 0);

    // Store then load round trip
    d_q.push_back('{we: 1, addr: 64'h100, wdata: 64'h0102030405060708, delay: 0});
    d_q.push_back('{we: 0, addr: 64'h100, wdata: 0, delay: 0});
    run_engine(60);
    chk("store_byte0", tb_mem['h100], 8'h08);
    chk("store_byte7", tb_mem['h107], 8'h01);
    chk("load_word", last_d_rdata, 64'h0102030405060708);

    // Arbitration from reset: both always pending
    do_reset();
    for (int i = 0; i < 2; i++) begin
      if_q.push_back('{we: 0, addr: 64'h2000, wdata: 0, delay: 0});
      d_q.push_back('{we: 0, addr: 64'h100, wdata: 0, delay: 0});
    end
    run_engine(80);
    chk("arb_count", grant_q.size(), 4);
    chk("arb_order", {grant_q[0], grant_q[1], grant_q[2], grant_q[3]}, 4'b0101);
    chk("arb_last_ack", last_ack_c, 35);

    // Range boundaries
    d_q.push_back('{we: 0, addr: 64'd524281, wdata: 0, delay: 0});
    run_engine(20);
    chk("range_over_cycle", last_ack_c, 1);
    chk("range_over_err", last_err, 1);
    d_q.push_back('{we: 1, addr: 64'd524280, wdata: 64'hA5A5_0F0F_1234_5678, delay: 0});
    run_engine(20);
    chk("range_edge_cycle", last_ack_c, 10);
    chk("range_edge_err", last_err, 0);
    chk("range_edge_mem", tb_mem[524287], 8'hA5);
    if_q.push_back('{we: 0, addr: 64'hFFFF_FFFF_FFFF_FFFE, wdata: 0, delay: 0});
    run_engine(20);
    chk("range_fetch_cycle", last_ack_c, 1);
    chk("range_fetch_err", last_err, 1);

    // Data request raised while a fetch is mid-transfer
    if_q.push_back('{we: 0, addr: 64'h2000, wdata: 0, delay: 0});
    d_q.push_back('{we: 0, addr: 64'h100, wdata: 0, delay: 2});
    run_engine(60);
    chk("hold_data_ack", last_ack_c, 17);

    // Reset in the middle of a store (cnt == 3)
    w = {$urandom, $urandom};
    @(negedge clk);
    d_we = 1; d_addr = 64'h300; d_wdata = w; d_req = 1;
    repeat (4) @(negedge clk);
    chk("mid_pre_en", mem_en, 1);
    chk("mid_pre_addr", mem_addr, 64'h303);
    reset = 0;
    #1;
    chk("mid_en", mem_en, 0);
    chk("mid_we", mem_we, 0);
    chk("mid_addr", mem_addr, 0);
    chk("mid_busy", busy, 0);
    chk("mid_d_ack", d_ack, 0);
    d_req = 0; d_we = 0;
    @(negedge clk);
    chk("mid_d_ack_hold", d_ack, 0);
    reset = 1;
    m_last_data = 1;
    for (int i = 0; i < 8; i++)
      chk("mid_mem", tb_mem['h300 + i], (i < 3) ? 64'(w[8*i +: 8]) : 64'(ref_mem['h300 + i]));
    for (int i = 0; i < 3; i++) ref_mem['h300 + i] = w[8*i +: 8];
    if_q.push_back('{we: 0, addr: 64'h300, wdata: 0, delay: 0});
    d_q.push_back('{we: 0, addr: 64'h300, wdata: 0, delay: 0});
    run_engine(60);
    chk("mid_first_grant", grant_q[0], 0);

    // Randomized traffic from both requesters
    for (int k = 0; k < 30; k++) begin
      if_q.push_back('{we: 0, addr: rand_addr(), wdata: 0, delay: $urandom_range(0, 4)});
      d_q.push_back('{we: 1'($urandom_range(0, 1)), addr: rand_addr(),
                      wdata: {$urandom, $urandom}, delay: $urandom_range(0, 4)});
    end
    run_engine(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
